// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter: prioritises faults/interrupts, drives CP0, flushes.
// Optional EXC_STATS_EN adds a wrapping count of exceptions taken (ERET excluded).
module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic [31:0]      pc_i,
  input  logic             is_in_delayslot_i,
  input  logic             exc_adel_if_i,
  input  logic             exc_ri_i,
  input  logic             exc_ov_i,
  input  logic             exc_sys_i,
  input  logic             exc_bp_i,
  input  logic             exc_eret_i,
  input  logic             exc_adel_ld_i,
  input  logic             exc_ades_st_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      cp0_status_i,
  input  logic [31:0]      cp0_cause_i,
  input  logic [31:0]      cp0_epc_i,
  input  logic             wb_cp0_we_i,
  input  logic [4:0]       wb_cp0_waddr_i,
  input  logic [31:0]      wb_cp0_wdata_i,
  output logic [4:0]       excepttype_o,
  output logic             is_in_delayslot_o,
  output logic [31:0]      current_inst_addr_o,
  output logic [31:0]      badvaddr_o,
  output logic             mem_kill_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic [CNT_W-1:0] exc_count_o
);

  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t      r_state, w_next;
  logic        r_flush;
  logic [31:0] r_new_pc;

  logic [31:0] w_eff_status, w_eff_epc;
  logic [1:0]  w_eff_sw;
  logic        w_fwd_st, w_fwd_ca, w_fwd_epc;
  logic        w_int_req, w_take;
  logic [4:0]  w_exc;
  logic [31:0] w_badv, w_cia, w_npc_d;
  logic        w_ds, w_flush_d;

  assign w_fwd_st  = wb_cp0_we_i && (wb_cp0_waddr_i == CP0_STATUS);
  assign w_fwd_ca  = wb_cp0_we_i && (wb_cp0_waddr_i == CP0_CAUSE);
  assign w_fwd_epc = wb_cp0_we_i && (wb_cp0_waddr_i == CP0_EPC);

  assign w_eff_status = w_fwd_st  ? wb_cp0_wdata_i      : cp0_status_i;
  assign w_eff_epc    = w_fwd_epc ? wb_cp0_wdata_i      : cp0_epc_i;
  assign w_eff_sw     = w_fwd_ca  ? wb_cp0_wdata_i[9:8] : cp0_cause_i[9:8];

  // IE set, EXL clear, and any unmasked hw or sw source pending
  assign w_int_req = w_eff_status[0] & ~w_eff_status[1] &
                     (|(cp0_cause_i[15:10] & w_eff_status[15:10]) |
                      |(w_eff_sw & w_eff_status[9:8]));

  assign w_take = (r_state == S_IDLE) & valid_i & ~stall_i;

  always_comb begin
    w_exc     = 5'd0;
    w_badv    = 32'd0;
    w_ds      = 1'b0;
    w_cia     = 32'd0;
    w_next    = r_state;
    w_flush_d = 1'b0;
    w_npc_d   = r_new_pc;
    if (r_state == S_IDLE) begin
      w_ds  = is_in_delayslot_i;
      w_cia = pc_i;
      if (w_take) begin
        if (w_int_req) w_exc = EXC_INT;
        else if (exc_adel_if_i) begin
          w_exc  = EXC_ADEL;
          w_badv = pc_i;
        end
        else if (exc_ri_i)   w_exc = EXC_RI;
        else if (exc_ov_i)   w_exc = EXC_OV;
        else if (exc_sys_i)  w_exc = EXC_SYS;
        else if (exc_bp_i)   w_exc = EXC_BP;
        else if (exc_eret_i) w_exc = EXC_ERET;
        else if (exc_adel_ld_i) begin
          w_exc  = EXC_ADEL;
          w_badv = mem_addr_i;
        end
        else if (exc_ades_st_i) begin
          w_exc  = EXC_ADES;
          w_badv = mem_addr_i;
        end
      end
      if (w_exc != 5'd0) begin
        w_next    = S_FLUSH;
        w_flush_d = 1'b1;
        w_npc_d   = (w_exc == EXC_ERET) ? w_eff_epc : EXC_VECTOR;
      end
    end else begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_flush  <= 1'b0;
      r_new_pc <= 32'd0;
    end else begin
      r_state  <= w_next;
      r_flush  <= w_flush_d;
      r_new_pc <= w_npc_d;
    end
  end

  assign excepttype_o        = w_exc;
  assign is_in_delayslot_o   = w_ds;
  assign current_inst_addr_o = w_cia;
  assign badvaddr_o          = w_badv;
  assign mem_kill_o          = (w_exc != 5'd0);
  assign flush_o             = r_flush;
  assign new_pc_o            = r_new_pc;

`ifdef EXC_STATS_EN
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_flush_d && (w_exc != EXC_ERET))
      r_cnt <= r_cnt + CNT_W'(1);
  end
  assign exc_count_o = r_cnt;
`else
  assign exc_count_o = '0;
`endif

  logic w_unused;
  assign w_unused = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                      cp0_cause_i[31:16], cp0_cause_i[7:0],
                      wb_cp0_wdata_i[31:10], wb_cp0_wdata_i[7:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// Scoreboard bench for except_ctrl: directed vectors queue expectations,
// a negedge monitor pops and compares each cycle's outputs.
module tb_except_ctrl;

  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, stall_i, is_in_delayslot_i;
  logic [31:0] pc_i, mem_addr_i;
  logic        exc_adel_if_i, exc_ri_i, exc_ov_i, exc_sys_i;
  logic        exc_bp_i, exc_eret_i, exc_adel_ld_i, exc_ades_st_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_wdata_i;
  logic [4:0]  excepttype_o;
  logic        is_in_delayslot_o, mem_kill_o, flush_o;
  logic [31:0] current_inst_addr_o, badvaddr_o, new_pc_o;
  logic [31:0] exc_count_o;

  except_ctrl dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .stall_i(stall_i), .pc_i(pc_i),
    .is_in_delayslot_i(is_in_delayslot_i),
    .exc_adel_if_i(exc_adel_if_i), .exc_ri_i(exc_ri_i),
    .exc_ov_i(exc_ov_i), .exc_sys_i(exc_sys_i),
    .exc_bp_i(exc_bp_i), .exc_eret_i(exc_eret_i),
    .exc_adel_ld_i(exc_adel_ld_i), .exc_ades_st_i(exc_ades_st_i),
    .mem_addr_i(mem_addr_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
    .wb_cp0_wdata_i(wb_cp0_wdata_i),
    .excepttype_o(excepttype_o),
    .is_in_delayslot_o(is_in_delayslot_o),
    .current_inst_addr_o(current_inst_addr_o),
    .badvaddr_o(badvaddr_o), .mem_kill_o(mem_kill_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o),
    .exc_count_o(exc_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [4:0]  et;
    logic [31:0] bad;
    logic        ds;
    logic [31:0] cia;
    logic        kill;
    logic        fl;
    logic [31:0] npc;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  logic [31:0] enpc = 32'd0;
  logic [31:0] ecnt = 32'd0;

  function automatic logic [31:0] cnt_exp();
`ifdef EXC_STATS_EN
    return ecnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic clr();
    valid_i = 0; stall_i = 0; pc_i = 0; is_in_delayslot_i = 0;
    exc_adel_if_i = 0; exc_ri_i = 0; exc_ov_i = 0; exc_sys_i = 0;
    exc_bp_i = 0; exc_eret_i = 0; exc_adel_ld_i = 0; exc_ades_st_i = 0;
    mem_addr_i = 0; cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
    wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_wdata_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic chk(input string nm, input logic [4:0] et,
                     input logic [31:0] bad, input logic ds,
                     input logic [31:0] cia, input logic kill,
                     input logic fl);
    exp_t e;
    e.nm = nm; e.et = et; e.bad = bad; e.ds = ds; e.cia = cia;
    e.kill = kill; e.fl = fl; e.npc = enpc; e.cnt = cnt_exp();
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_total++;
      if (excepttype_o === e.et && badvaddr_o === e.bad &&
          is_in_delayslot_o === e.ds &&
          current_inst_addr_o === e.cia &&
          mem_kill_o === e.kill && flush_o === e.fl &&
          new_pc_o === e.npc && exc_count_o === e.cnt)
        n_pass++;
      else
        $display("FAIL %s: got et=%h bad=%h ds=%b cia=%h kill=%b fl=%b npc=%h cnt=%0d want et=%h bad=%h ds=%b cia=%h kill=%b fl=%b npc=%h cnt=%0d",
                 e.nm, excepttype_o, badvaddr_o, is_in_delayslot_o,
                 current_inst_addr_o, mem_kill_o, flush_o, new_pc_o,
                 exc_count_o, e.et, e.bad, e.ds, e.cia, e.kill, e.fl,
                 e.npc, e.cnt);
    end
  end

  initial begin
    rst = 1;
    clr();
    tick();
    chk("reset", 0, 0, 0, 0, 0, 0);
    tick(); rst = 0;
    chk("post_rst", 0, 0, 0, 0, 0, 0);

    // overflow
    tick(); valid_i = 1; pc_i = 32'h8000_0100; exc_ov_i = 1;
    chk("ov_T", EXC_OV, 0, 0, 32'h8000_0100, 1, 0);
    ecnt++; enpc = VEC;
    tick(); chk("ov_T1", 0, 0, 0, 0, 0, 1);
    tick(); chk("ov_T2", 0, 0, 0, 0, 0, 0);

    // load misaligned in delay slot
    tick(); valid_i = 1; pc_i = 32'h8000_0200; exc_adel_ld_i = 1;
    mem_addr_i = 32'h1000_0003; is_in_delayslot_i = 1;
    chk("adel_ld", EXC_ADEL, 32'h1000_0003, 1, 32'h8000_0200, 1, 0);
    ecnt++;
    tick(); chk("adel_ld_T1", 0, 0, 0, 0, 0, 1);
    tick();

    // eret with forwarded EPC
    tick(); valid_i = 1; pc_i = 32'h8000_0300; exc_eret_i = 1;
    cp0_epc_i = 32'h8000_0000; wb_cp0_we_i = 1;
    wb_cp0_waddr_i = 5'd14; wb_cp0_wdata_i = 32'h8000_2000;
    chk("eret", EXC_ERET, 0, 0, 32'h8000_0300, 1, 0);
    enpc = 32'h8000_2000;
    tick(); chk("eret_T1", 0, 0, 0, 0, 0, 1);
    tick(); chk("eret_T2", 0, 0, 0, 0, 0, 0);

    // interrupt deferred across bubbles and a stall
    for (int i = 0; i < 2; i++) begin
      tick(); cp0_status_i = 32'h401; cp0_cause_i = 32'h400;
      pc_i = 32'h8000_0400;
      chk("def_bubble", 0, 0, 0, 32'h8000_0400, 0, 0);
    end
    tick(); cp0_status_i = 32'h401; cp0_cause_i = 32'h400;
    pc_i = 32'h8000_0400; valid_i = 1; stall_i = 1;
    chk("def_stall", 0, 0, 0, 32'h8000_0400, 0, 0);
    tick(); cp0_status_i = 32'h401; cp0_cause_i = 32'h400;
    pc_i = 32'h8000_0404; valid_i = 1;
    chk("def_int", EXC_INT, 0, 0, 32'h8000_0404, 1, 0);
    ecnt++; enpc = VEC;
    tick(); chk("def_int_T1", 0, 0, 0, 0, 0, 1);
    tick();

    // eret loses to pending interrupt
    tick(); cp0_status_i = 32'h401; cp0_cause_i = 32'h400;
    valid_i = 1; pc_i = 32'h8000_0500; exc_eret_i = 1;
    cp0_epc_i = 32'h8000_0040;
    chk("eret_vs_int", EXC_INT, 0, 0, 32'h8000_0500, 1, 0);
    ecnt++;
    tick(); chk("eret_vs_int_T1", 0, 0, 0, 0, 0, 1);
    tick();

    // mtc0 Status clearing IE suppresses the interrupt
    tick(); cp0_status_i = 32'h401; cp0_cause_i = 32'h400;
    valid_i = 1; pc_i = 32'h8000_0510; wb_cp0_we_i = 1;
    wb_cp0_waddr_i = 5'd12; wb_cp0_wdata_i = 32'h400;
    chk("ie_fwd_clear", 0, 0, 0, 32'h8000_0510, 0, 0);

    // software interrupt via forwarded Cause
    tick(); cp0_status_i = 32'h101; valid_i = 1; pc_i = 32'h8000_0520;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd13; wb_cp0_wdata_i = 32'h100;
    chk("sw_int_fwd", EXC_INT, 0, 0, 32'h8000_0520, 1, 0);
    ecnt++;
    tick(); chk("sw_int_T1", 0, 0, 0, 0, 0, 1);
    tick();

    // RI beats SYS
    tick(); valid_i = 1; pc_i = 32'h8000_0540; exc_ri_i = 1; exc_sys_i = 1;
    chk("ri_sys", EXC_RI, 0, 0, 32'h8000_0540, 1, 0);
    ecnt++;
    tick(); tick();

    // EXL masks the interrupt
    tick(); cp0_status_i = 32'h403; cp0_cause_i = 32'h400;
    valid_i = 1; pc_i = 32'h8000_0550; exc_ri_i = 1; exc_sys_i = 1;
    chk("ri_exl", EXC_RI, 0, 0, 32'h8000_0550, 1, 0);
    ecnt++;
    tick(); tick();

    // every flag: fetch ADEL wins, badvaddr is the PC
    tick(); valid_i = 1; pc_i = 32'h8000_0602; mem_addr_i = 32'h1234_5679;
    exc_adel_if_i = 1; exc_ri_i = 1; exc_ov_i = 1; exc_sys_i = 1;
    exc_bp_i = 1; exc_eret_i = 1; exc_adel_ld_i = 1; exc_ades_st_i = 1;
    chk("all_flags", EXC_ADEL, 32'h8000_0602, 0, 32'h8000_0602, 1, 0);
    ecnt++;
    tick(); tick();

    // store misaligned
    tick(); valid_i = 1; pc_i = 32'h8000_0700; exc_ades_st_i = 1;
    mem_addr_i = 32'h2000_0002;
    chk("ades", EXC_ADES, 32'h2000_0002, 0, 32'h8000_0700, 1, 0);
    ecnt++;
    tick(); tick();

    // flush cycle blanks a new break
    tick(); valid_i = 1; pc_i = 32'h8000_0800; exc_ov_i = 1;
    chk("blank_T", EXC_OV, 0, 0, 32'h8000_0800, 1, 0);
    ecnt++;
    tick(); valid_i = 1; pc_i = 32'h8000_0804; exc_bp_i = 1;
    chk("blank_T1", 0, 0, 0, 0, 0, 1);
    tick(); valid_i = 1; pc_i = 32'h8000_0804; exc_bp_i = 1;
    chk("bp_T2", EXC_BP, 0, 0, 32'h8000_0804, 1, 0);
    ecnt++;
    tick(); chk("bp_T3", 0, 0, 0, 0, 0, 1);
    tick();

    // reset during flush
    tick(); valid_i = 1; pc_i = 32'h8000_0900; exc_sys_i = 1;
    chk("rst_T", EXC_SYS, 0, 0, 32'h8000_0900, 1, 0);
    ecnt++;
    tick(); rst = 1;
    chk("rst_T1", 0, 0, 0, 0, 0, 1);
    ecnt = 0; enpc = 0;
    tick(); rst = 0;
    chk("rst_T2", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
